alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
Front-end sequencer that drives the 32-bit ALU's operand/opcode inputs and collects its result. Accepts tagged operation requests on a valid/ready channel and buffers them in a small FIFO. Issues one operation per ALU cycle, captures the combinational ALU result, and returns tagged responses on a second valid/ready channel. Sits between the instruction/command source and the ALU instance.

Parameters:
WIDTH, 32, operand/result width; must match the ALU.
TAG_W, 4, request tag width; the tag is returned unchanged with the response.
REQ_DEPTH, 2, request FIFO entries; power of two, 2 or more.
CNT_W, 16, width of the issued-operation counter.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request FIFO can accept
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
req_opcode  in  3  ALU opcode
req_tag  in  TAG_W  request tag
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_opcode  out  3  to ALU opcode
alu_result  in  WIDTH  from ALU result (combinational, same cycle)
rsp_valid  out  1  response valid
rsp_ready  in  1  downstream accepts response
rsp_result  out  WIDTH  captured result
rsp_tag  out  TAG_W  tag of the completed request
rsp_illegal  out  1  opcode not supported by the ALU
op_count  out  CNT_W  number of completed issues; saturates

Behaviour:
- Reset, when rst=1 at a clock edge:
  - FIFO empty, FSM in IDLE.
  - req_ready=1 on the next cycle; rsp_valid=0; rsp_result=0; rsp_tag=0; rsp_illegal=0; op_count=0.
  - alu_a, alu_b and alu_opcode driven to 0.
  - Any in-flight request or response is discarded; nothing is replayed.
- Request handshake:
  - A request is accepted on the edge where req_valid and req_ready are both 1.
  - req_ready = FIFO not full; it is registered state only, with no combinational path from rsp_ready.
  - Push and pop in the same cycle are allowed when the FIFO is full: req_ready stays 0 that cycle, and the pop frees a slot for the next cycle.
- Issue path (combinational from state):
  - alu_a, alu_b and alu_opcode = FIFO head fields when the FSM is in ISSUE, otherwise 0.
- FSM states:
  - IDLE: the FIFO is empty. Go to ISSUE when the FIFO becomes non-empty.
  - ISSUE (one cycle):
    - Pop the head.
    - Capture alu_result into rsp_result.
    - rsp_tag = head tag.
    - rsp_illegal = (head opcode != 3'b000).
    - Increment op_count, saturating at all-ones.
    - Go to RESP.
  - RESP: rsp_valid=1, with rsp fields held stable until accepted. On rsp_valid and rsp_ready:
    - FIFO non-empty after this cycle: go to ISSUE.
    - FIFO empty: go to IDLE.
    - A request pushed into an empty FIFO in this same cycle counts as non-empty.
- Latency:
  - Request accepted at edge t enters ISSUE in cycle t+1.
  - rsp_valid is asserted from cycle t+2.
  - Throughput is one op per 2 cycles with rsp_ready tied high.
- Ordering: strictly in order; tags are never reordered.
- Arithmetic: result width is WIDTH. Carry-out is ignored, so A + B wraps modulo 2^WIDTH, as produced by the ALU.
- Illegal opcodes: still issued to the ALU; the ALU returns 0, which is passed through with rsp_illegal=1. This is not an error stall.
- Backpressure: while in RESP with rsp_ready=0, the FIFO keeps filling until full, then req_ready=0.

Decomposition:
- Package alu_pkg:
  - opcode typedef enum logic [2:0] with OP_ADD=3'b000.
  - request struct {a, b, opcode, tag}.
  - FSM state enum {IDLE, ISSUE, RESP}.
  - Function is_supported(opcode).
- Sub-module alu_req_fifo: parameterised synchronous FIFO of the request struct, with full/empty flags and same-cycle push/pop support.

Test Plan:
- Single add: A=5, B=7, op=000, tag=3 -> rsp_valid in cycle t+2; result=12, tag=3, illegal=0; op_count=1.
- Wrap-around: A=32'hFFFF_FFFF, B=1, op=000 -> result=0, illegal=0.
- Illegal opcode: op=3'b011, A=9, B=9, tag=7 -> alu_opcode=3'b011 seen in ISSUE; result=0, illegal=1, tag=7.
- Backpressure: rsp_ready=0, push tags 1,2,3 back-to-back -> tag 1 held in RESP; tags 2,3 fill FIFO; req_ready=0. Raise rsp_ready -> responses arrive in order 1,2,3, each 2 cycles apart.
- Reset mid-operation: two requests queued, response pending, assert rst for 1 cycle -> next cycle rsp_valid=0, op_count=0, req_ready=1, alu_* =0; no stale responses later.
- Counter saturation with CNT_W=2: issue 5 ops -> op_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/alu_issue_unit_pkg.sv
// Shared types for the ALU issue unit: opcodes, request record, FSM states
// and the opcode legality check.
package alu_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_TAG_W = 4;

    // Only ADD is implemented by the ALU; every other encoding is illegal.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000
    } opcode_e;

    // Default request record; the top builds an equivalent record sized by
    // its own WIDTH/TAG_W parameters.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
        logic [2:0]           opcode;
        logic [DEF_TAG_W-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    function automatic logic is_supported(input logic [2:0] opcode);
        return opcode == OP_ADD;
    endfunction

endpackage

// File: rtl/alu_issue_unit_fifo.sv
// Request FIFO: power-of-two depth, registered occupancy count, full/empty
// flags derived from state only, push and pop allowed in the same cycle.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter type         entry_t = req_t,
    parameter int unsigned DEPTH   = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    entry_t        mem_q [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A push while full only lands if the same cycle also pops.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so the order of statements here does not matter.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; entries are only
        // read once the count marks them valid, and leaving them unreset keeps
        // them plain RAM.
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue unit: buffers tagged requests, drives one op per ISSUE cycle to
// the combinational ALU, captures the result and returns a tagged response.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned REQ_DEPTH = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_opcode,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] op_count
);

    // Request record sized to this instance's parameters.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       opcode;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t push_data;
    entry_t head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   push;
    logic   pop;

    state_e state_q;
    state_e state_d;

    logic [WIDTH-1:0] rsp_result_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             rsp_illegal_q;
    logic [CNT_W-1:0] op_count_q;
    logic [CNT_W-1:0] op_count_d;

    // Ready depends on FIFO occupancy only, never on the response side.
    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == ISSUE);

    assign push_data = '{a: req_a, b: req_b, opcode: req_opcode, tag: req_tag};

    alu_req_fifo #(
        .entry_t (entry_t),
        .DEPTH   (REQ_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Next-state logic. A push landing this cycle counts as work pending so
    // a request accepted at edge t is in ISSUE during cycle t+1.
    always_comb begin
        // NOTE: assigning the default first means every path drives state_d,
        // so no latch is inferred when a branch leaves it untouched.
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (push || !fifo_empty) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = (push || !fifo_empty) ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating count of completed issues.
    always_comb begin
        op_count_d = op_count_q;
        if (state_q == ISSUE && op_count_q != '1) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    // Drive the ALU from the FIFO head only while issuing.
    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = '0;
        if (state_q == ISSUE) begin
            alu_a      = head.a;
            alu_b      = head.b;
            alu_opcode = head.opcode;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Response capture and op counter; fields hold while RESP waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result_q  <= '0;
            rsp_tag_q     <= '0;
            rsp_illegal_q <= 1'b0;
            op_count_q    <= '0;
        end else begin
            op_count_q <= op_count_d;
            if (state_q == ISSUE) begin
                rsp_result_q  <= alu_result;
                rsp_tag_q     <= head.tag;
                rsp_illegal_q <= !is_supported(head.opcode);
            end
        end
    end

    assign rsp_valid   = (state_q == RESP);
    assign rsp_result  = rsp_result_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_illegal = rsp_illegal_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: table-driven single ops plus
// backpressure and mid-operation reset sequences. A second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_opcode;
    logic [3:0]  req_tag;
    logic        rsp_ready;

    logic        req_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic        rsp_illegal;
    logic [15:0] op_count;

    logic        s_req_ready;
    logic [31:0] s_alu_a;
    logic [31:0] s_alu_b;
    logic [2:0]  s_alu_opcode;
    logic [31:0] s_alu_result;
    logic        s_rsp_valid;
    logic [31:0] s_rsp_result;
    logic [3:0]  s_rsp_tag;
    logic        s_rsp_illegal;
    logic [1:0]  s_op_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Reference ALU: ADD only, everything else returns zero.
    assign alu_result   = (alu_opcode == 3'b000)   ? alu_a + alu_b     : 32'd0;
    assign s_alu_result = (s_alu_opcode == 3'b000) ? s_alu_a + s_alu_b : 32'd0;

    alu_issue_unit #(.WIDTH(32), .TAG_W(4), .REQ_DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal), .op_count(op_count)
    );

    alu_issue_unit #(.WIDTH(32), .TAG_W(4), .REQ_DEPTH(2), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(s_req_ready),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_tag(req_tag),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_opcode(s_alu_opcode), .alu_result(s_alu_result),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(s_rsp_result),
        .rsp_tag(s_rsp_tag), .rsp_illegal(s_rsp_illegal), .op_count(s_op_count)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [3:0]  tag;
        logic [31:0] exp_result;
        logic        exp_illegal;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Push one request with rsp_ready high and follow it through ISSUE and RESP.
    task automatic run_vec(input vec_t v, input int exp_cnt, input int exp_small);
        req_a      = v.a;
        req_b      = v.b;
        req_opcode = v.op;
        req_tag    = v.tag;
        req_valid  = 1'b1;
        check("req_ready idle", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("issue alu_a", {32'd0, alu_a}, {32'd0, v.a});
        check("issue alu_b", {32'd0, alu_b}, {32'd0, v.b});
        check("issue alu_opcode", {61'd0, alu_opcode}, {61'd0, v.op});
        check("issue rsp_valid low", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("rsp_result", {32'd0, rsp_result}, {32'd0, v.exp_result});
        check("rsp_tag", {60'd0, rsp_tag}, {60'd0, v.tag});
        check("rsp_illegal", {63'd0, rsp_illegal}, {63'd0, v.exp_illegal});
        check("op_count", {48'd0, op_count}, 64'(exp_cnt));
        check("op_count sat2", {62'd0, s_op_count}, 64'(exp_small));
        check("alu idle in resp", {29'd0, alu_opcode, alu_a}, 64'd0);
        @(negedge clk);
        check("rsp_valid after accept", {63'd0, rsp_valid}, 64'd0);
    endtask

    task automatic push_req(input logic [3:0] tag);
        req_a      = {28'd0, tag};
        req_b      = 32'd100;
        req_opcode = 3'b000;
        req_tag    = tag;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] got_tag [3];
        logic [31:0] got_res [3];
        int         got_cyc [3];
        int         n_rsp;

        vecs[0] = '{a: 32'd5,          b: 32'd7,          op: 3'b000, tag: 4'd3,  exp_result: 32'd12,         exp_illegal: 1'b0};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          op: 3'b000, tag: 4'd1,  exp_result: 32'd0,          exp_illegal: 1'b0};
        vecs[2] = '{a: 32'd9,          b: 32'd9,          op: 3'b011, tag: 4'd7,  exp_result: 32'd0,          exp_illegal: 1'b1};
        vecs[3] = '{a: 32'h8000_0000,  b: 32'h8000_0001,  op: 3'b000, tag: 4'd0,  exp_result: 32'd1,          exp_illegal: 1'b0};
        vecs[4] = '{a: 32'h1234_5678,  b: 32'h1111_1111,  op: 3'b000, tag: 4'd10, exp_result: 32'h2345_6789,  exp_illegal: 1'b0};
        vecs[5] = '{a: 32'd1,          b: 32'd2,          op: 3'b111, tag: 4'd15, exp_result: 32'd0,          exp_illegal: 1'b1};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_opcode = '0;
        req_tag    = '0;
        rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        check("reset req_ready", {63'd0, req_ready}, 64'd1);
        check("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset rsp_result", {32'd0, rsp_result}, 64'd0);
        check("reset rsp_tag", {60'd0, rsp_tag}, 64'd0);
        check("reset rsp_illegal", {63'd0, rsp_illegal}, 64'd0);
        check("reset op_count", {48'd0, op_count}, 64'd0);
        check("reset alu outputs", {29'd0, alu_opcode, alu_a | alu_b}, 64'd0);

        // Table-driven single ops; the 2-bit counter saturates at 3.
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i + 1, (i + 1 > 3) ? 3 : i + 1);
        end

        // Backpressure: tag 1 parks in RESP, tags 2 and 3 fill the FIFO.
        rsp_ready = 1'b0;
        push_req(4'd1);
        push_req(4'd2);
        check("bp req_ready before last push", {63'd0, req_ready}, 64'd1);
        push_req(4'd3);
        check("bp req_ready full", {63'd0, req_ready}, 64'd0);
        check("bp rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("bp rsp_tag", {60'd0, rsp_tag}, 64'd1);
        repeat (2) @(negedge clk);
        check("bp rsp_tag held", {60'd0, rsp_tag}, 64'd1);
        check("bp rsp_result held", {32'd0, rsp_result}, 64'd101);
        check("bp req_ready held", {63'd0, req_ready}, 64'd0);

        rsp_ready = 1'b1;
        n_rsp = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid) begin
                if (n_rsp < 3) begin
                    got_tag[n_rsp] = rsp_tag;
                    got_res[n_rsp] = rsp_result;
                    got_cyc[n_rsp] = c;
                end
                n_rsp++;
            end
            @(negedge clk);
        end
        check("bp response count", 64'(n_rsp), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < n_rsp) begin
                check("bp order tag", {60'd0, got_tag[k]}, 64'(k + 1));
                check("bp result", {32'd0, got_res[k]}, 64'(k + 101));
                check("bp spacing", 64'(got_cyc[k]), 64'(2 * k));
            end
        end
        check("bp req_ready drained", {63'd0, req_ready}, 64'd1);

        // Reset with a response pending and two requests queued.
        rsp_ready = 1'b0;
        push_req(4'd4);
        push_req(4'd5);
        push_req(4'd6);
        check("pre-reset rsp_valid", {63'd0, rsp_valid}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("mid reset op_count", {48'd0, op_count}, 64'd0);
        check("mid reset op_count sat2", {62'd0, s_op_count}, 64'd0);
        check("mid reset req_ready", {63'd0, req_ready}, 64'd1);
        check("mid reset alu outputs", {29'd0, alu_opcode, alu_a | alu_b}, 64'd0);
        check("mid reset rsp_tag", {60'd0, rsp_tag}, 64'd0);
        rsp_ready = 1'b1;
        n_rsp = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid) n_rsp++;
            @(negedge clk);
        end
        check("no stale responses", 64'(n_rsp), 64'd0);

        // Unit still works after the mid-operation reset.
        run_vec(vecs[0], 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
